uart_ram_loader: RTL and testbench

//  Host-side debug loader on the UART RX pin: deserialises 8N1 bytes, parses a load frame
//  and writes 32-bit words into system RAM through the RAM debug override path.

---
 rtl/uart_ram_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// UART (8N1) debug loader: receives a load frame on rxd and writes 32-bit
// words into RAM through the debug override port. The CPU is held in reset
// while a frame is in progress.
module uart_ram_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        override_ctrl,
  output logic        cpu_hold,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ready,
  output logic        load_done,
  output logic        load_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_DONE} state_t;

  // rx path state
  logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic          rxd_prev_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          byte_valid, frame_err;

  // frame FSM state
  state_t        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   sr_q, sr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rem_q, rem_d;
  logic          hold_vld_q, hold_vld_d;
  logic [7:0]    hold_q, hold_d;
  logic          err_q, err_d;

  logic          in_vld;
  logic [7:0]    in_byte;
  logic [31:0]   word;

  // State register for both the rx deserialiser and the frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sr_q    <= '0;
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      sr_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rem_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rem_q      <= rem_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
    end
  end

  // Rx deserialiser: falling edge starts a byte, mid-bit sampling, stop check.
  // byte_valid fires in the stop-sample cycle, while rx_sr_q holds the byte.
  always_comb begin
    rxd_prev_d = rxd_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sr_d    = rx_sr_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // a line that is high again by mid-start was a glitch
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sr_d  = {rxd_s2_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rxd_s2_q;
          frame_err  = !rxd_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame FSM next state: byte collection, write handshake, error aborts
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sr_d       = sr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rem_d      = rem_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    err_d      = err_q;
    // a byte parked during WRITE takes priority over a fresh one
    in_vld     = hold_vld_q | byte_valid;
    in_byte    = hold_vld_q ? hold_q : rx_sr_q;
    word       = {in_byte, sr_q[31:8]};

    if (state_q inside {S_IDLE, S_ADDR, S_CNT, S_DATA}) begin
      if (hold_vld_q) begin
        hold_vld_d = byte_valid;
        hold_d     = rx_sr_q;
      end
      if (in_vld) begin
        sr_d   = word;
        bcnt_d = bcnt_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_vld && in_byte == SYNC_BYTE) begin
          state_d = S_ADDR;
          bcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (in_vld && bcnt_q == 2'd3) begin
          addr_d  = {word[31:2], 2'b00};
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (in_vld && bcnt_q == 2'd3) begin
          rem_d   = word;
          state_d = (word == 32'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (in_vld && bcnt_q == 2'd3) begin
          wdata_d = word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (byte_valid && hold_vld_q) begin
          // second byte with nowhere to go: overrun abort
          err_d      = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          if (byte_valid) begin
            hold_vld_d = 1'b1;
            hold_d     = rx_sr_q;
          end
          if (ram_ready) begin
            addr_d  = addr_q + 32'd4;
            rem_d   = rem_q - 32'd1;
            state_d = (rem_q == 32'd1) ? S_DONE : S_DATA;
          end
        end
      end
      S_DONE: begin
        hold_vld_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_err) begin
      err_d      = 1'b1;
      hold_vld_d = 1'b0;
      state_d    = S_IDLE;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    override_ctrl = (state_q != S_IDLE);
    cpu_hold      = (state_q != S_IDLE);
    ram_wen       = (state_q == S_WRITE);
    load_done     = (state_q == S_DONE);
    ram_addr      = addr_q;
    ram_wdata     = wdata_q;
    load_err      = err_q;
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: table of load frames plus hand-written sequences
// for framing error, overrun and mid-frame reset. Writes are scoreboarded.
module tb_uart_ram_loader;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst, rxd, ram_ready;
  logic        override_ctrl, cpu_hold, ram_wen, load_done, load_err;
  logic [31:0] ram_addr, ram_wdata;

  uart_ram_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .override_ctrl(override_ctrl), .cpu_hold(cpu_hold),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ready(ram_ready), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr; int cnt;
    logic [31:0] d0, d1;
    logic [31:0] ea0, ea1;
  } vec_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0, tot_cnt = 0;
  int  done_cnt = 0, wr_cnt = 0, hold_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_hold !== override_ctrl) hold_mis++;
      if (ram_wen && !override_ctrl) hold_mis++;
      if (load_done) done_cnt++;
      if (ram_wen && ram_ready) begin
        wr_t e;
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", ram_addr, 32'hxxxxxxxx);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_wdata, e.d);
        end
      end
    end
  end

  task automatic bit_period(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop);
    bit_period(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  vec_t vecs[4];

  initial begin
    int d0, w0;
    wr_t e;
    vecs[0] = '{32'h0000_1000, 2, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1000, 32'h0000_1004};
    vecs[1] = '{32'h0000_4000, 0, 32'h0,         32'h0,         32'h0,         32'h0};
    vecs[2] = '{32'hFFFF_FFFE, 2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_2003, 1, 32'hA5A5_A5A5, 32'h0,         32'h0000_2000, 32'h0};

    rst = 1'b1; rxd = 1'b1; ram_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_override", {31'd0, override_ctrl}, 32'd0);
    chk("rst_outputs", {27'd0, cpu_hold, ram_wen, load_done, load_err, |ram_addr}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // table of complete frames
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt; w0 = wr_cnt;
      send_byte(8'hA5);
      chk($sformatf("v%0d_override_after_sync", v), {31'd0, override_ctrl}, 32'd1);
      send_word(vecs[v].addr);
      send_word(vecs[v].cnt);
      for (int k = 0; k < vecs[v].cnt; k++) begin
        e.a = (k == 0) ? vecs[v].ea0 : vecs[v].ea1;
        e.d = (k == 0) ? vecs[v].d0  : vecs[v].d1;
        exp_q.push_back(e);
        send_word(e.d);
      end
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 32'd1);
      chk($sformatf("v%0d_writes", v), wr_cnt - w0, vecs[v].cnt);
      chk($sformatf("v%0d_pending", v), exp_q.size(), 32'd0);
      chk($sformatf("v%0d_override_end", v), {31'd0, override_ctrl}, 32'd0);
      chk($sformatf("v%0d_err", v), {31'd0, load_err}, 32'd0);
    end

    // framing error inside COUNT, then recovery
    d0 = done_cnt; w0 = wr_cnt;
    send_byte(8'hA5);
    send_word(32'h0000_5000);
    send_byte(8'h02, 1'b0);
    chk("ferr_err", {31'd0, load_err}, 32'd1);
    chk("ferr_override", {31'd0, override_ctrl}, 32'd0);
    send_byte(8'hA5);
    chk("ferr_err_cleared", {31'd0, load_err}, 32'd0);
    send_word(32'h0000_6000);
    send_word(32'd1);
    e.a = 32'h0000_6000; e.d = 32'h1122_3344; exp_q.push_back(e);
    send_word(e.d);
    repeat (20) @(negedge clk);
    chk("ferr_recover_done", done_cnt - d0, 32'd1);
    chk("ferr_recover_writes", wr_cnt - w0, 32'd1);

    // overrun while RAM stalls
    ram_ready = 1'b0;
    w0 = wr_cnt;
    send_byte(8'hA5);
    send_word(32'h0000_3000);
    send_word(32'd2);
    send_word(32'h0102_0304);
    chk("ovr_wen_stall", {31'd0, ram_wen}, 32'd1);
    chk("ovr_addr_stable", ram_addr, 32'h0000_3000);
    chk("ovr_data_stable", ram_wdata, 32'h0102_0304);
    send_byte(8'h55);
    chk("ovr_first_held", {30'd0, ram_wen, load_err}, 32'd2);
    send_byte(8'h66);
    chk("ovr_err", {31'd0, load_err}, 32'd1);
    chk("ovr_wen_drop", {31'd0, ram_wen}, 32'd0);
    chk("ovr_override", {31'd0, override_ctrl}, 32'd0);
    repeat (10 * CPB) @(negedge clk);
    ram_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("ovr_no_writes", wr_cnt - w0, 32'd0);

    // reset in the middle of the second data byte
    send_byte(8'hA5);
    send_word(32'h0000_7000);
    send_word(32'd1);
    send_byte(8'hAA);
    rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {27'd0, override_ctrl, cpu_hold, ram_wen, load_done, load_err}, 32'd0);
    rst = 1'b0; rxd = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h5A);
    chk("rst_garbage_idle", {31'd0, override_ctrl}, 32'd0);
    d0 = done_cnt; w0 = wr_cnt;
    send_byte(8'hA5);
    send_word(32'h0000_8000);
    send_word(32'd1);
    e.a = 32'h0000_8000; e.d = 32'h9988_7766; exp_q.push_back(e);
    send_word(e.d);
    repeat (20) @(negedge clk);
    chk("rst_recover_done", done_cnt - d0, 32'd1);
    chk("rst_recover_writes", wr_cnt - w0, 32'd1);

    chk("final_pending", exp_q.size(), 32'd0);
    chk("hold_tracks_override", hold_mis, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
